frame_draw_ctrl: RTL and testbench
==================================

// Module: frame_draw_ctrl
// PURPOSE
//  Write-side front end of the 640x480 frame RAM. It sits directly upstream of the frame RAM
//  write port and drives its write address, write data and write enable.
//  Accepts pixel draw requests (x, y, colour) from game logic over a valid/ready handshake,
//  buffered in a small FIFO. Also runs a full-screen clear sweep on command.
//  Converts (x, y) to the linear address y*H_RES + x. Issues at most one RAM write per cycle.
// PARAMETERS
//  H_RES       640  horizontal pixels per line
//  V_RES       480  lines per frame
//  ADDR_W      19   frame RAM address width
//  COLOR_W     5    palette index width
//  FIFO_DEPTH  4    draw-request buffer entries (power of 2)
// PORTS
//  Clk          in   1        system clock, all state on rising edge
//  Reset        in   1        asynchronous, active-high reset
//  clear_req    in   1        1-cycle pulse: start full-screen clear
//  clear_color  in   COLOR_W  colour used by the clear; latched when the clear starts
//  req_valid    in   1        draw request valid
//  req_ready    out  1        FIFO can accept a request (= !fifo_full)
//  req_x        in   10       pixel column
//  req_y        in   9        pixel row
//  req_color    in   COLOR_W  pixel colour
//  fr_addr      out  ADDR_W   to frame RAM write address (registered)
//  fr_data      out  COLOR_W  to frame RAM write data (registered)
//  fr_we        out  1        to frame RAM write enable (registered)
//  busy         out  1        state != IDLE or FIFO non-empty
//  clear_done   out  1        1-cycle pulse when the clear finishes
//  oob_err      out  1        1-cycle pulse when an out-of-range request is dropped
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, clear counter=0.
//   fr_addr=0, fr_data=0, fr_we=0, busy=0, clear_done=0, oob_err=0, req_ready=1.
//  Handshake: push on req_valid&&req_ready. req_ready comes only from the registered count.
//   When the FIFO is full, a pop in the same cycle does not admit a push.
//  FSM states: IDLE, DRAW, CLEAR.
//   IDLE -> CLEAR on clear_req. This has priority over a non-empty FIFO.
//   IDLE -> DRAW when the FIFO is non-empty.
//   DRAW: pops 1 entry per cycle. Goes to CLEAR if clear_req is seen; the in-flight write completes first.
//   DRAW -> IDLE when the FIFO is empty.
//   CLEAR: counter walks 0..H_RES*V_RES-1, one write per cycle, fr_data=latched clear_color.
//   CLEAR -> IDLE after the last address. clear_done pulses the next cycle.
//   clear_req while in CLEAR is ignored, with no restart.
//  Requests keep being accepted during CLEAR until the FIFO is full.
//   Queued draws run after the clear, so they survive it.
//  Address: fr_addr = (y<<9)+(y<<7)+x, computed in ADDR_W bits using shift-add (no multiplier).
//  Latency: a request accepted at cycle N produces fr_we=1 at N+2 when the FIFO was empty and the state was IDLE.
//   Sustained throughput is 1 write/cycle.
//  fr_we is high for exactly 1 cycle per write. fr_addr/fr_data hold their last value while fr_we=0.
//  Reset asserted mid-clear or mid-draw: writes stop immediately.
//   The FIFO contents and the clear progress are lost; there is no resume.
// CONFIGURATION
//  FRAME_BOUNDS_CHECK_EN defined:
//   A popped entry with x>=H_RES or y>=V_RES produces no write.
//   oob_err pulses 1 cycle at the slot where that write would have occurred.
//  FRAME_BOUNDS_CHECK_EN undefined:
//   No check; the address is computed and truncated modulo 2^ADDR_W; oob_err is tied 0.
// TESTING
//  1 Reset, then req (x=3,y=2,c=7) at N -> fr_we=1 only at N+2, fr_addr=1283, fr_data=7.
//  2 req (639,479,c=31) -> fr_addr=307199, fr_data=31. req (0,0) -> fr_addr=0.
//  3 clear_req, clear_color=4 -> 307200 consecutive writes at addr 0..307199, data 4.
//    clear_done pulses 1 cycle after addr 307199; busy falls the same cycle.
//  4 During CLEAR, hold req_valid with 6 distinct reqs -> exactly 4 accepted and req_ready=0.
//    After clear_done, the 4 writes occur on consecutive cycles in order.
//  5 Reset pulsed at clear addr 1000 -> fr_we=0 asynchronously; after release busy=0 and no further writes.
//  6 req (640,0): with FRAME_BOUNDS_CHECK_EN -> no fr_we, oob_err 1-cycle pulse.
//    Without the macro -> write at fr_addr=640.

Source files
------------

// File: rtl/frame_draw_if.sv
// frame_draw_if: pixel draw request handshake between game logic and the frame RAM write front end
interface frame_draw_if #(parameter int COLOR_W = 5);
  logic               req_valid;
  logic               req_ready;
  logic [9:0]         req_x;
  logic [8:0]         req_y;
  logic [COLOR_W-1:0] req_color;
  modport master (output req_valid, req_x, req_y, req_color, input req_ready);
  modport slave (input req_valid, req_x, req_y, req_color, output req_ready);
endinterface

// File: rtl/frame_draw_ctrl.sv
// frame_draw_ctrl: buffered pixel draws and full-screen clear into the frame RAM write port (optional FRAME_BOUNDS_CHECK_EN drops off-screen draws)
module frame_draw_ctrl #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  frame_draw_if.slave        req,
  output logic [ADDR_W-1:0]  fr_addr,
  output logic [COLOR_W-1:0] fr_data,
  output logic               fr_we,
  output logic               busy,
  output logic               clear_done,
  output logic               oob_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 19 + COLOR_W;
  typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;
  state_t             state, state_nx;
  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]      wp, rp;
  logic [PW:0]        count;
  logic [ADDR_W-1:0]  pix, draw_addr, wr_addr;
  logic [COLOR_W-1:0] clr_col, wr_data, hc;
  logic [9:0]         hx;
  logic [8:0]         hy;
  logic               push, pop, empty, last, start, ok, wr_en, oob, pend;
  assign req.req_ready = count != (PW+1)'(FIFO_DEPTH);
  assign empty         = count == '0;
  assign push          = req.req_valid && req.req_ready;
  assign pop           = state == DRAW && !empty;
  assign {hx, hy, hc}  = mem[rp];
  assign draw_addr     = (ADDR_W'(hy) << 9) + (ADDR_W'(hy) << 7) + ADDR_W'(hx);
  assign last          = pix == ADDR_W'(H_RES * V_RES - 1);
  assign start         = clear_req && state != CLEAR;
  // pend keeps busy high until the clear_done pulse so both fall/rise together
  assign busy          = state != IDLE || !empty || pend;
`ifdef FRAME_BOUNDS_CHECK_EN
  assign ok = hx < 10'(H_RES) && hy < 9'(V_RES);
`else
  assign ok = 1'b1;
`endif
  // request buffer storage, written on every accepted handshake
  always_ff @(posedge Clk)
    if (push) mem[wp] <= {req.req_x, req.req_y, req.req_color};
  // request buffer pointers and occupancy
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + PW'(push);
      rp    <= rp + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  // clear sweep position and the colour captured when the sweep starts
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      pix     <= '0;
      clr_col <= '0;
    end else if (start) begin
      pix     <= '0;
      clr_col <= clear_color;
    end else if (state == CLEAR) pix <= pix + 1'b1;
  // state register
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  // next state: a clear pre-empts queued draws, which then run once it ends
  always_comb
    state_nx = state == CLEAR ? (last ? IDLE : CLEAR) : clear_req ? CLEAR : empty ? IDLE : DRAW;
  // write selection for this cycle: sweep pixel or popped draw
  always_comb begin
    wr_en   = state == CLEAR || (pop && ok);
    wr_addr = state == CLEAR ? pix : draw_addr;
    wr_data = state == CLEAR ? clr_col : hc;
    oob     = pop && !ok;
  end
  // registered frame RAM port and status pulses; address/data hold between writes
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      fr_addr    <= '0;
      fr_data    <= '0;
      fr_we      <= 1'b0;
      oob_err    <= 1'b0;
      pend       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      fr_we      <= wr_en;
      oob_err    <= oob;
      pend       <= state == CLEAR && last;
      clear_done <= pend;
      if (wr_en) begin
        fr_addr <= wr_addr;
        fr_data <= wr_data;
      end
    end
endmodule

// File: tb/tb_frame_draw_ctrl.sv
// tb_frame_draw_ctrl: randomized and directed checks of frame_draw_ctrl against a queue-based reference model
module tb_frame_draw_ctrl;
  localparam int VR   = 16;
  localparam int NPIX = 640 * VR;
  logic        Clk = 0, Reset = 1, clear_req = 0;
  logic [4:0]  clear_color = 0;
  logic [18:0] fr_addr;
  logic [4:0]  fr_data;
  logic        fr_we, busy, clear_done, oob_err;
  int          n_cmp = 0, n_bad = 0;
  typedef struct {int x; int y; int c;} req_t;
  req_t q[$];
  req_t tbl[6];
  frame_draw_if #(.COLOR_W(5)) bus();
  frame_draw_ctrl #(.V_RES(VR)) dut (
    .Clk(Clk), .Reset(Reset), .clear_req(clear_req), .clear_color(clear_color), .req(bus),
    .fr_addr(fr_addr), .fr_data(fr_data), .fr_we(fr_we), .busy(busy),
    .clear_done(clear_done), .oob_err(oob_err)
  );
  always #5 Clk = ~Clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic bit in_range(int x, int y);
`ifdef FRAME_BOUNDS_CHECK_EN
    return x < 640 && y < VR;
`else
    return 1'b1;
`endif
  endfunction
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic observe;
    req_t e;
    if (fr_we || oob_err) begin
      if (q.size() == 0) check("spurious_write", {fr_we, oob_err}, 0);
      else begin
        e = q.pop_front();
        check("write_vs_oob", fr_we, in_range(e.x, e.y));
        check("oob_pulse", oob_err, !in_range(e.x, e.y));
        if (fr_we) begin
          check("addr", fr_addr, (e.y * 640 + e.x) % (1 << 19));
          check("data", fr_data, e.c);
        end
      end
    end
  endtask
  task automatic drive(bit v, int x, int y, int c);
    if (bus.req_valid && bus.req_ready) q.push_back('{int'(bus.req_x), int'(bus.req_y), int'(bus.req_color)});
    tick;
    observe();
    bus.req_valid = v;
    bus.req_x     = 10'(x);
    bus.req_y     = 9'(y);
    bus.req_color = 5'(c);
  endtask
  initial begin
    int k, n, errs, x, y;
    bit acc;
    bus.req_valid = 0; bus.req_x = 0; bus.req_y = 0; bus.req_color = 0;
    repeat (2) tick;
    check("rst_we", fr_we, 0);
    check("rst_addr", fr_addr, 0);
    check("rst_data", fr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_oob", oob_err, 0);
    check("rst_ready", bus.req_ready, 1);
    Reset = 0;
    tick;
    bus.req_valid = 1; bus.req_x = 3; bus.req_y = 2; bus.req_color = 7;
    tick;
    bus.req_valid = 0;
    check("t1_n0_we", fr_we, 0);
    tick;
    check("t1_n1_we", fr_we, 0);
    tick;
    check("t1_n2_we", fr_we, 1);
    check("t1_addr", fr_addr, 1283);
    check("t1_data", fr_data, 7);
    tick;
    check("t1_n3_we", fr_we, 0);
    check("t1_hold", fr_addr, 1283);
    drive(1, 639, 479, 31);
    drive(1, 0, 0, 5);
    drive(1, 640, 0, 3);
    drive(1, 17, 3, 12);
    repeat (12) drive(0, 0, 0, 0);
    check("t2_drained", q.size(), 0);
    repeat (400) begin
      x = ($urandom_range(0, 7) == 0) ? $urandom_range(640, 1023) : $urandom_range(0, 639);
      y = ($urandom_range(0, 7) == 0) ? $urandom_range(VR, 511) : $urandom_range(0, VR - 1);
      drive($urandom_range(0, 9) < 7, x, y, $urandom_range(0, 31));
    end
    repeat (15) drive(0, 0, 0, 0);
    check("rand_drained", q.size(), 0);
    clear_color = 4; clear_req = 1;
    tick;
    clear_req = 0;
    check("t3_start_we", fr_we, 0);
    check("t3_busy", busy, 1);
    errs = 0;
    for (int i = 0; i < NPIX; i++) begin
      tick;
      if (!(fr_we === 1 && fr_addr === 19'(i) && fr_data === 4 && clear_done === 0 && busy === 1)) errs++;
    end
    check("t3_sweep_errs", errs, 0);
    check("t3_last_addr", fr_addr, NPIX - 1);
    tick;
    check("t3_done", clear_done, 1);
    check("t3_busy_fall", busy, 0);
    check("t3_we_off", fr_we, 0);
    tick;
    check("t3_done_pulse", clear_done, 0);
    for (int j = 0; j < 6; j++) tbl[j] = '{100 + j * 37, j + 1, j + 20};
    clear_color = 9; clear_req = 1;
    tick;
    clear_req = 0;
    k = 0;
    bus.req_valid = 1; bus.req_x = 10'(tbl[0].x); bus.req_y = 9'(tbl[0].y); bus.req_color = 5'(tbl[0].c);
    repeat (20) begin
      acc = bus.req_valid && bus.req_ready;
      if (acc) k++;
      tick;
      if (k < 6) begin
        bus.req_x = 10'(tbl[k].x); bus.req_y = 9'(tbl[k].y); bus.req_color = 5'(tbl[k].c);
      end
    end
    check("t4_accepted", k, 4);
    check("t4_ready", bus.req_ready, 0);
    bus.req_valid = 0;
    n = 0;
    while (!clear_done && n < NPIX + 50) begin
      tick;
      n++;
    end
    check("t4_done_seen", clear_done, 1);
    for (int j = 0; j < 4; j++) begin
      tick;
      check("t4_we", fr_we, 1);
      check("t4_addr", fr_addr, tbl[j].y * 640 + tbl[j].x);
      check("t4_data", fr_data, tbl[j].c);
    end
    tick;
    check("t4_we_end", fr_we, 0);
    clear_color = 2; clear_req = 1;
    tick;
    clear_req = 0;
    n = 0;
    while (!(fr_we && fr_addr == 1000) && n < 2000) begin
      tick;
      n++;
    end
    check("t5_reached", fr_addr, 1000);
    #2 Reset = 1;
    #1;
    check("t5_async_we", fr_we, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_addr", fr_addr, 0);
    tick;
    tick;
    Reset = 0;
    n = 0;
    repeat (50) begin
      tick;
      n += int'(fr_we);
    end
    check("t5_no_writes", n, 0);
    check("t5_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
